led_pattern_shifter: RTL
========================

# led_pattern_shifter

Parametrised LED pattern generator, successor to the fixed 8-bit left-rotating shifter. Prescales the system clock to a configurable step rate and, on each step, updates a WIDTH-bit LED register according to the selected mode: rotate, bounce, Johnson (twisted-ring) or hold. Supports run/pause, direction select and synchronous pattern load. Sits directly in front of the board LED pins.

## Interface

Parameters:

- `WIDTH`, default 8: number of LEDs, must be ≥ 2.
- `CLK_FREQ`, default 25_000_000: clock frequency in Hz.
- `STEP_HZ`, default 4: pattern steps per second.
- `INIT`, default 'h1F, WIDTH bits: `leds` value after reset.

Ports:

- `clk` input 1: system clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `en` input 1: 1 = prescaler runs; 0 = prescaler and pattern frozen.
- `dir` input 1: 0 = toward MSB (left); 1 = toward LSB (right).
- `mode` input 2: 00 rotate, 01 bounce, 10 Johnson, 11 hold.
- `load` input 1: synchronous pattern load strobe.
- `load_val` input WIDTH: pattern written on `load`.
- `leds` output WIDTH: registered LED pattern.
- `step` output 1: registered one-cycle pulse, high in the cycle `leds` shows a tick-driven update.

## Operation

Prescaler:

- `CYCLES` = `CLK_FREQ` / `STEP_HZ`, clamped to a minimum of 1.
- Counter `cnt` is `$clog2(CYCLES)` bits, minimum 1.
- When `en`=1, `cnt` counts 0..`CYCLES`-1 and wraps. `tick` = `en` & (`cnt` == `CYCLES`-1).
- When `en`=0, `cnt` holds its value; no tick occurs.

Priority per cycle:

1. `load` is highest. Sets `leds` <= `load_val`, `cnt` <= 0, `pos` <= 0, `bdir` <= `dir`. `step` = 0. A coincident tick is discarded. `load` acts regardless of `en`.
2. Otherwise, on `tick`, apply the mode:
   - **Rotate (00):** left is {leds[W-2:0], leds[W-1]}; right is {leds[0], leds[W-1:1]}.
   - **Bounce (01):** rotate in internal direction `bdir`. `pos` counts 0..WIDTH-2. On the tick where `pos` == WIDTH-2, the rotation still happens, then `pos` <= 0 and `bdir` toggles. Each sweep is therefore exactly WIDTH-1 steps.
   - **Johnson (10):** left is {leds[W-2:0], ~leds[W-1]}; right is {~leds[0], leds[W-1:1]}. Period is 2·WIDTH steps.
   - **Hold (11):** `leds` unchanged and `step` not asserted. The prescaler keeps running.
3. Whenever `mode` != 01, `pos` <= 0 and `bdir` <= `dir` every cycle. Entering bounce therefore always starts a fresh sweep in direction `dir`.

Mode and direction changes:

- `mode` and `dir` are sampled only at tick or load. Changes between ticks take effect at the next tick.
- `dir` is ignored while in bounce, except when loaded into `bdir` at entry or on `load`.

## Timing

- Reset values: `leds`=`INIT`, `step`=0, `cnt`=0, `pos`=0, `bdir`=0.
- First tick comes `CYCLES` rising edges after `rst_n` deasserts with `en`=1. Subsequent ticks are every `CYCLES` edges while `en`=1.
- `leds` and `step` update on the same edge. `step` is high for exactly one cycle per non-hold tick.
- With `CYCLES`=1, a tick occurs every enabled cycle.
- Pausing (`en` 1→0→1) resumes the count from the held `cnt`. No step is lost or duplicated.
- Asserting `rst_n`=0 mid-operation forces all reset values immediately, without waiting for a clock edge.

## Configuration

- Macro `LED_SHIFTER_BOUNCE_EN`.
- **Defined:** bounce mode is implemented as above, including the `pos` and `bdir` registers.
- **Not defined:** `pos` and `bdir` are not instantiated, and `mode`=01 behaves exactly as rotate (00).

## Test plan

All scenarios use WIDTH=8, CLK_FREQ=16, STEP_HZ=4, so CYCLES=4.

- **Reset and rotate:** reset, `en`=1, `mode`=00, `dir`=0. `leds`=1F after reset; 3E at edge 4 with `step` pulse; 7C at edge 8. After 8 ticks `leds`=1F again.
- **Right rotate and Johnson:** `load` 01, `dir`=1, `mode`=00. First tick gives 80. Then `load` 00, `mode`=10, `dir`=0, giving 01, 03, 07, … FF, FE, … 00 over 16 ticks.
- **Bounce (macro defined):** `load` 01, `mode`=01, `dir`=0. `leds` goes 02, 04, … 80 over 7 ticks, then 40, 20, … 01 over the next 7.
  - Without the macro, the 8th tick gives 01 (plain rotate).
- **Pause and hold:** with `en`=0 for 10 cycles mid-count, the next step arrives after the remaining count. In `mode`=11, `leds` stays stable with no `step` pulse over 3 tick periods.
- **Load vs tick:** assert `load`=A5 in the tick cycle. `leds`=A5, `step`=0, next tick 4 edges later gives 4B.
- **Async reset:** drop `rst_n` between clock edges mid-bounce. `leds`=1F and `step`=0 immediately; after release, rotate resumes from 1F.

Source files
------------

// File: rtl/led_pattern_shifter.sv
// LED pattern generator: prescaled step tick drives rotate / bounce / Johnson / hold on a WIDTH-bit register.
// Optional bounce mode is built only when LED_SHIFTER_BOUNCE_EN is defined; otherwise mode 01 rotates.
module led_pattern_shifter #(
  parameter int              WIDTH    = 8,
  parameter int              CLK_FREQ = 25_000_000,
  parameter int              STEP_HZ  = 4,
  parameter logic [WIDTH-1:0] INIT    = WIDTH'('h1F)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] leds,
  output logic             step
);

  localparam int CYCLES_RAW = CLK_FREQ / STEP_HZ;
  localparam int CYCLES     = (CYCLES_RAW < 1) ? 1 : CYCLES_RAW;
  localparam int CNT_W      = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CYCLES - 1);

  localparam logic [1:0] MODE_ROTATE  = 2'b00;
  localparam logic [1:0] MODE_BOUNCE  = 2'b01;
  localparam logic [1:0] MODE_JOHNSON = 2'b10;

  logic [CNT_W-1:0] cnt;
  logic             tick;
  logic [WIDTH-1:0] leds_nxt;
  logic             step_nxt;
  logic [WIDTH-1:0] rot_l, rot_r, jon_l, jon_r;

  assign tick = en && (cnt == CNT_MAX);

  // Prescaler: load restarts the step period so the next update is a full period away.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= '0;
    end else if (en) begin
      if (cnt == CNT_MAX) cnt <= '0;
      else                cnt <= cnt + CNT_W'(1);
    end
  end

  assign rot_l = {leds[WIDTH-2:0], leds[WIDTH-1]};
  assign rot_r = {leds[0], leds[WIDTH-1:1]};
  assign jon_l = {leds[WIDTH-2:0], ~leds[WIDTH-1]};
  assign jon_r = {~leds[0], leds[WIDTH-1:1]};

`ifdef LED_SHIFTER_BOUNCE_EN
  localparam int POS_W = (WIDTH > 2) ? $clog2(WIDTH - 1) : 1;
  localparam logic [POS_W-1:0] POS_LAST = POS_W'(WIDTH - 2);

  logic [POS_W-1:0] pos;
  logic             bdir;

  // Outside bounce the sweep state tracks dir, so entering bounce starts a fresh sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos  <= '0;
      bdir <= 1'b0;
    end else if (load || (mode != MODE_BOUNCE)) begin
      pos  <= '0;
      bdir <= dir;
    end else if (tick) begin
      if (pos == POS_LAST) begin
        pos  <= '0;
        bdir <= ~bdir;
      end else begin
        pos <= pos + POS_W'(1);
      end
    end
  end
`endif

  always_comb begin
    leds_nxt = leds;
    step_nxt = 1'b0;
    if (load) begin
      leds_nxt = load_val;
    end else if (tick) begin
      case (mode)
        MODE_ROTATE: begin
          leds_nxt = dir ? rot_r : rot_l;
          step_nxt = 1'b1;
        end
        MODE_BOUNCE: begin
`ifdef LED_SHIFTER_BOUNCE_EN
          leds_nxt = bdir ? rot_r : rot_l;
`else
          leds_nxt = dir ? rot_r : rot_l;
`endif
          step_nxt = 1'b1;
        end
        MODE_JOHNSON: begin
          leds_nxt = dir ? jon_r : jon_l;
          step_nxt = 1'b1;
        end
        default: begin
          leds_nxt = leds;
          step_nxt = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      leds <= INIT;
      step <= 1'b0;
    end else begin
      leds <= leds_nxt;
      step <= step_nxt;
    end
  end

endmodule
